// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder: one BLOCK-bit slice resolved per stage, with the slice carry registered into the next stage.
// Optional macro SIGNED_OVF_EN builds the registered signed-overflow output; otherwise ovf is tied to 0.
module pipelined_csel_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / BLOCK;

    logic adv;

    // One shared advance keeps every stage in lockstep, so stalls never drop or duplicate ops.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv || rst;

    function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                              input logic [BLOCK-1:0] y,
                                              input logic             c);
        logic [BLOCK:0]   cy;
        logic [BLOCK-1:0] s;
        cy[0] = c;
        for (int i = 0; i < BLOCK; i++) begin
            s[i]    = x[i] ^ y[i] ^ cy[i];
            cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
        end
        return {cy[BLOCK], s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        localparam int IN_W  = WIDTH - k * BLOCK;
        localparam int SUM_W = (k + 1) * BLOCK;

        logic [IN_W-1:0]  aIn;
        logic [IN_W-1:0]  bIn;
        logic             cIn;
        logic             vIn;
        logic [BLOCK:0]   rZero;
        logic [BLOCK:0]   rOne;
        logic [BLOCK:0]   rSel;
        logic [SUM_W-1:0] sumD;
        logic [SUM_W-1:0] sum_q;
        logic             valid_q;
        logic             carry_q;

        if (k == 0) begin : gIn
            assign aIn  = a;
            assign bIn  = b;
            assign cIn  = cin;
            assign vIn  = in_valid;
            assign sumD = rSel[BLOCK-1:0];
        end else begin : gIn
            assign aIn  = gStage[k-1].gSkew.aSkew_q;
            assign bIn  = gStage[k-1].gSkew.bSkew_q;
            assign cIn  = gStage[k-1].carry_q;
            assign vIn  = gStage[k-1].valid_q;
            assign sumD = {rSel[BLOCK-1:0], gStage[k-1].sum_q};
        end

        assign rZero = ripple(aIn[BLOCK-1:0], bIn[BLOCK-1:0], 1'b0);
        assign rOne  = ripple(aIn[BLOCK-1:0], bIn[BLOCK-1:0], 1'b1);
        assign rSel  = cIn ? rOne : rZero;

        // Only the output-facing stage clears its data; inner data is gated by the valid bits.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                if (k == STAGES - 1) begin
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                end
            end else if (adv) begin
                valid_q <= vIn;
                sum_q   <= sumD;
                carry_q <= rSel[BLOCK];
            end
        end

        if (k < STAGES - 1) begin : gSkew
            logic [IN_W-BLOCK-1:0] aSkew_q;
            logic [IN_W-BLOCK-1:0] bSkew_q;

            always_ff @(posedge clk) begin
                if (adv) begin
                    aSkew_q <= aIn[IN_W-1:BLOCK];
                    bSkew_q <= bIn[IN_W-1:BLOCK];
                end
            end
        end

`ifdef SIGNED_OVF_EN
        if (k == STAGES - 1) begin : gOvf
            logic ovfD;
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit rather than a second ripple tap.
            assign ovfD = aIn[BLOCK-1] ^ bIn[BLOCK-1] ^ rSel[BLOCK-1] ^ rSel[BLOCK];

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovfD;
                end
            end
        end
`endif
    end

    assign out_valid = gStage[STAGES-1].valid_q;
    assign sum       = gStage[STAGES-1].sum_q;
    assign cout      = gStage[STAGES-1].carry_q;

`ifdef SIGNED_OVF_EN
    assign ovf = gStage[STAGES-1].gOvf.ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench for pipelined_csel_adder (WIDTH=16, BLOCK=4) using directed vectors.
// A negedge monitor pops expected results whenever the DUT hands one over.
module tb_pipelined_csel_adder;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } expT;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [15:0] aDrv;
    logic [15:0] bDrv;
    logic        cinDrv;
    logic        outValid;
    logic        outReady;
    logic [15:0] sumOut;
    logic        coutOut;
    logic        ovfOut;

    expT expQ[$];
    int  total = 0;
    int  bad   = 0;

    pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .a         (aDrv),
        .b         (bDrv),
        .cin       (cinDrv),
        .out_valid (outValid),
        .out_ready (outReady),
        .sum       (sumOut),
        .cout      (coutOut),
        .ovf       (ovfOut)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%04h required=0x%04h at %0t", name, act, req, $time);
        end
    endtask

    // Issues one op and waits (bounded) for it to be accepted; expected result is queued on acceptance.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic c,
                                 input logic [15:0] es, input logic ec, input logic eo);
        expT e;
        int  waitCnt = 0;
        bit  done    = 0;
        aDrv    = av;
        bDrv    = bv;
        cinDrv  = c;
        inValid = 1'b1;
        e.s = es;
        e.c = ec;
`ifdef SIGNED_OVF_EN
        e.o = eo;
`else
        e.o = 1'b0;
        if (eo) e.o = 1'b0;
`endif
        while (!done) begin
            #1;
            if (inReady) begin
                expQ.push_back(e);
                done = 1;
            end
            @(posedge clk);
            @(negedge clk);
            if (!done) begin
                waitCnt++;
                if (waitCnt > 50) begin
                    checkOutput("accept_timeout", 16'h0, 16'h1);
                    done = 1;
                end
            end
        end
        inValid = 1'b0;
    endtask

    always @(negedge clk) begin
        expT e;
        if (!rst && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 16'h1, 16'h0);
            end else begin
                e = expQ.pop_front();
                checkOutput("sum", sumOut, e.s);
                checkOutput("cout", {15'h0, coutOut}, {15'h0, e.c});
                checkOutput("ovf", {15'h0, ovfOut}, {15'h0, e.o});
            end
        end
    end

    initial begin
        int lat;
        int guard;
        rst      = 1'b1;
        inValid  = 1'b0;
        aDrv     = 16'h0;
        bDrv     = 16'h0;
        cinDrv   = 1'b0;
        outReady = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", {15'h0, outValid}, 16'h0);
        checkOutput("rst_sum", sumOut, 16'h0000);
        checkOutput("rst_cout", {15'h0, coutOut}, 16'h0);
        checkOutput("rst_ovf", {15'h0, ovfOut}, 16'h0);
        checkOutput("rst_in_ready", {15'h0, inReady}, 16'h1);
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        lat = 1;
        while (!outValid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat[15:0], 16'd4);
        @(negedge clk);

        applyStimulus(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
        repeat (6) @(negedge clk);

        applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        repeat (6) @(negedge clk);

        // Fill with the output blocked, then hold the stall and check the head op stays put.
        outReady = 1'b0;
        applyStimulus(16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        applyStimulus(16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_in_ready", {15'h0, inReady}, 16'h0);
            checkOutput("stall_out_valid", {15'h0, outValid}, 16'h1);
            checkOutput("stall_sum", sumOut, 16'h0300);
            @(negedge clk);
        end
        outReady = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("drain_empty", expQ.size() > 0 ? 16'h1 : 16'h0, 16'h0);

        applyStimulus(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        applyStimulus(16'h4444, 16'h4444, 1'b0, 16'h8888, 1'b0, 1'b1);
        rst = 1'b1;
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("post_rst_out_valid", {15'h0, outValid}, 16'h0);
        repeat (6) @(negedge clk);
        applyStimulus(16'h000E, 16'h0005, 1'b1, 16'h0014, 1'b0, 1'b0);

        guard = 0;
        while (expQ.size() > 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("final_drain", expQ.size() > 0 ? 16'h1 : 16'h0, 16'h0);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
